// File: rtl/bcd_updown_counter.sv
// rtl/bcd_updown_counter.sv - multi-decade up/down BCD counter with load, wrap/saturate and terminal count
// Optional compare output (cmp_val/match) enabled by defining BCD_CNT_MATCH_EN.
module bcd_updown_counter #(
    parameter int DIGITS = 2,
    parameter int WRAP   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
`ifdef BCD_CNT_MATCH_EN
    input  logic [4*DIGITS-1:0]   cmp_val,
    output logic                  match,
`endif
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic [DIGITS-1:0]     digit_wrap,
    output logic                  err
);

    logic [4*DIGITS-1:0] step_val;
    logic [DIGITS-1:0]   step_wrap;
    logic                carry;
    logic                at_max;
    logic                at_min;
    logic                at_bound;
    logic                load_ok;
    logic [3:0]          d;

    // Ripple a single carry/borrow up through the decades: a digit steps only
    // while every lower digit rolled over on this same edge.
    always_comb begin
        step_val  = count;
        step_wrap = '0;
        carry     = 1'b1;
        at_max    = 1'b1;
        at_min    = 1'b1;
        load_ok   = 1'b1;
        d         = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            d = count[4*i +: 4];
            if (d != 4'd9) at_max = 1'b0;
            if (d != 4'd0) at_min = 1'b0;
            if (load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
            if (carry) begin
                if (up) begin
                    if (d == 4'd9) begin
                        step_val[4*i +: 4] = 4'd0;
                        step_wrap[i]       = 1'b1;
                    end else begin
                        step_val[4*i +: 4] = d + 4'd1;
                        carry              = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        step_val[4*i +: 4] = 4'd9;
                        step_wrap[i]       = 1'b1;
                    end else begin
                        step_val[4*i +: 4] = d - 4'd1;
                        carry              = 1'b0;
                    end
                end
            end
        end
        at_bound = up ? at_max : at_min;
    end

    assign tc = en & ~load & at_bound;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count      <= '0;
            digit_wrap <= '0;
            err        <= 1'b0;
        end else begin
            digit_wrap <= '0;
            if (load) begin
                if (load_ok) count <= load_val;
                else         err   <= 1'b1;
            end else if (en) begin
                // In saturate mode the bound is sticky: no step, no wrap strobe.
                if (!at_bound || (WRAP != 0)) begin
                    count      <= step_val;
                    digit_wrap <= step_wrap;
                end
            end
        end
    end

`ifdef BCD_CNT_MATCH_EN
    assign match = reset & (count == cmp_val);
`endif

endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb/tb_bcd_updown_counter.sv - randomized and directed self-checking bench for bcd_updown_counter
module tb_bcd_updown_counter;

    localparam int DIGITS = 2;
    localparam int NMAX   = 99;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic en = 1'b0;
    logic up = 1'b1;
    logic load = 1'b0;
    logic [4*DIGITS-1:0] load_val = '0;
    logic [4*DIGITS-1:0] cmp_val = '0;

    // index 0: WRAP=1 instance, index 1: WRAP=0 instance
    logic [4*DIGITS-1:0] cnt [2];
    logic                tcv [2];
    logic [DIGITS-1:0]   dwv [2];
    logic                errv [2];
    logic                mat [2];

    int mv [2];
    logic [DIGITS-1:0] mdw [2];
    logic merr [2];

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bcd_updown_counter #(.DIGITS(DIGITS), .WRAP(1)) dut_w (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
`ifdef BCD_CNT_MATCH_EN
        .cmp_val(cmp_val), .match(mat[0]),
`endif
        .count(cnt[0]), .tc(tcv[0]), .digit_wrap(dwv[0]), .err(errv[0])
    );

    bcd_updown_counter #(.DIGITS(DIGITS), .WRAP(0)) dut_s (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
`ifdef BCD_CNT_MATCH_EN
        .cmp_val(cmp_val), .match(mat[1]),
`endif
        .count(cnt[1]), .tc(tcv[1]), .digit_wrap(dwv[1]), .err(errv[1])
    );

`ifndef BCD_CNT_MATCH_EN
    assign mat[0] = 1'b0;
    assign mat[1] = 1'b0;
`endif

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [4*DIGITS-1:0] v);
        for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int bcd2int(input logic [4*DIGITS-1:0] v);
        int r = 0;
        for (int i = 0; i < DIGITS; i++) r += int'(v[4*i +: 4]) * pow10(i);
        return r;
    endfunction

    function automatic logic [4*DIGITS-1:0] int2bcd(input int v);
        logic [4*DIGITS-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic logic exp_tc(input int k);
        return en && !load && (up ? (mv[k] == NMAX) : (mv[k] == 0));
    endfunction

    // Reference: count held as a plain integer; a decade wraps when the lower
    // (i+1) decimal digits sit at their extreme before the step.
    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            mdw[k] = '0;
            if (!reset) begin
                mv[k] = 0;
                merr[k] = 1'b0;
            end else if (load) begin
                if (bcd_ok(load_val)) mv[k] = bcd2int(load_val);
                else merr[k] = 1'b1;
            end else if (en) begin
                if (!(k == 1 && mv[k] == (up ? NMAX : 0))) begin
                    if (up) begin
                        for (int i = 0; i < DIGITS; i++)
                            if (mv[k] % pow10(i+1) == pow10(i+1) - 1) mdw[k][i] = 1'b1;
                        mv[k] = (mv[k] + 1) % (NMAX + 1);
                    end else begin
                        for (int i = 0; i < DIGITS; i++)
                            if (mv[k] % pow10(i+1) == 0) mdw[k][i] = 1'b1;
                        mv[k] = (mv[k] + NMAX) % (NMAX + 1);
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input logic r, input logic e, input logic u, input logic l,
                         input logic [4*DIGITS-1:0] lv);
        reset = r; en = e; up = u; load = l; load_val = lv;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h33);
        tick(); tick();
        n_cmp++; if (cnt[0] !== 8'h00) begin n_fail++; $display("FAIL reset_count got %h exp 00", cnt[0]); end
        n_cmp++; if (errv[0] !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", errv[0]); end
        n_cmp++; if (dwv[0] !== 2'b00) begin n_fail++; $display("FAIL reset_dw got %b exp 00", dwv[0]); end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++;
            if (cnt[0] !== int2bcd(i)) begin n_fail++; $display("FAIL release_count%0d got %h exp %h", i, cnt[0], int2bcd(i)); end
        end
    endtask

    task automatic test_up_wrap();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) tick();
        n_cmp++; if (cnt[0] !== 8'h10) begin n_fail++; $display("FAIL up10_count got %h exp 10", cnt[0]); end
        n_cmp++; if (dwv[0] !== 2'b01) begin n_fail++; $display("FAIL up10_dw got %b exp 01", dwv[0]); end
        tick();
        n_cmp++; if (dwv[0] !== 2'b00) begin n_fail++; $display("FAIL up11_dw got %b exp 00", dwv[0]); end
        for (int i = 0; i < 88; i++) tick();
        n_cmp++; if (cnt[0] !== 8'h99) begin n_fail++; $display("FAIL up99_count got %h exp 99", cnt[0]); end
        n_cmp++; if (tcv[0] !== 1'b1) begin n_fail++; $display("FAIL up99_tc got %b exp 1", tcv[0]); end
        tick();
        n_cmp++; if (cnt[0] !== 8'h00) begin n_fail++; $display("FAIL upwrap_count got %h exp 00", cnt[0]); end
        n_cmp++; if (dwv[0] !== 2'b11) begin n_fail++; $display("FAIL upwrap_dw got %b exp 11", dwv[0]); end
        n_cmp++; if (cnt[1] !== 8'h99) begin n_fail++; $display("FAIL upsat_count got %h exp 99", cnt[1]); end
        n_cmp++; if (dwv[1] !== 2'b00) begin n_fail++; $display("FAIL upsat_dw got %b exp 00", dwv[1]); end
    endtask

    task automatic test_down_bound();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        n_cmp++; if (tcv[0] !== 1'b1) begin n_fail++; $display("FAIL down0_tc_w got %b exp 1", tcv[0]); end
        n_cmp++; if (tcv[1] !== 1'b1) begin n_fail++; $display("FAIL down0_tc_s got %b exp 1", tcv[1]); end
        tick();
        n_cmp++; if (cnt[0] !== 8'h99) begin n_fail++; $display("FAIL downwrap_count got %h exp 99", cnt[0]); end
        n_cmp++; if (dwv[0] !== 2'b11) begin n_fail++; $display("FAIL downwrap_dw got %b exp 11", dwv[0]); end
        n_cmp++; if (cnt[1] !== 8'h00) begin n_fail++; $display("FAIL downsat_count got %h exp 00", cnt[1]); end
        n_cmp++; if (tcv[1] !== 1'b1) begin n_fail++; $display("FAIL downsat_tc got %b exp 1", tcv[1]); end
        n_cmp++; if (dwv[1] !== 2'b00) begin n_fail++; $display("FAIL downsat_dw got %b exp 00", dwv[1]); end
    endtask

    task automatic test_load();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h47);
        n_cmp++; if (tcv[0] !== 1'b0) begin n_fail++; $display("FAIL load_tc got %b exp 0", tcv[0]); end
        tick();
        n_cmp++; if (cnt[0] !== 8'h47) begin n_fail++; $display("FAIL load_count got %h exp 47", cnt[0]); end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h4A);
        tick();
        n_cmp++; if (cnt[0] !== 8'h47) begin n_fail++; $display("FAIL badload_count got %h exp 47", cnt[0]); end
        n_cmp++; if (errv[0] !== 1'b1) begin n_fail++; $display("FAIL badload_err got %b exp 1", errv[0]); end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_cmp++; if (errv[0] !== 1'b1) begin n_fail++; $display("FAIL err_sticky%0d got %b exp 1", i, errv[0]); end
            n_cmp++; if (cnt[0] !== int2bcd(47 + i)) begin n_fail++; $display("FAIL postload_count%0d got %h exp %h", i, cnt[0], int2bcd(47 + i)); end
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        tick();
        n_cmp++; if (errv[0] !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b exp 0", errv[0]); end
    endtask

    task automatic test_mid_op();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h56);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h12);
        tick();
        n_cmp++; if (cnt[0] !== 8'h00) begin n_fail++; $display("FAIL midreset_count got %h exp 00", cnt[0]); end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h10);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        n_cmp++; if (cnt[0] !== 8'h09) begin n_fail++; $display("FAIL reverse_count got %h exp 09", cnt[0]); end
        n_cmp++; if (dwv[0] !== 2'b01) begin n_fail++; $display("FAIL reverse_dw got %b exp 01", dwv[0]); end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        tick();
        n_cmp++; if (cnt[0] !== 8'h10) begin n_fail++; $display("FAIL reverse_up_count got %h exp 10", cnt[0]); end
    endtask

`ifdef BCD_CNT_MATCH_EN
    task automatic test_match();
        cmp_val = 8'h25;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h20);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        for (int v = 21; v <= 27; v++) begin
            tick();
            n_cmp++;
            if (mat[0] !== (v == 25)) begin n_fail++; $display("FAIL match_at%0d got %b exp %b", v, mat[0], (v == 25)); end
        end
        cmp_val = 8'h00;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        n_cmp++; if (mat[0] !== 1'b0) begin n_fail++; $display("FAIL match_in_reset got %b exp 0", mat[0]); end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        n_cmp++; if (mat[0] !== 1'b1) begin n_fail++; $display("FAIL match_after_reset got %b exp 1", mat[0]); end
    endtask
`endif

    task automatic test_random();
        logic [4*DIGITS-1:0] lv;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 2) == 0) lv = 8'($urandom);
            else lv = int2bcd(int'($urandom_range(0, NMAX)));
            cmp_val = ($urandom_range(0, 1) == 0) ? int2bcd(mv[0]) : int2bcd(int'($urandom_range(0, NMAX)));
            drive(($urandom_range(0, 59) != 0), ($urandom_range(0, 4) != 0),
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0), lv);
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (tcv[k] !== exp_tc(k)) begin n_fail++; $display("FAIL rnd_tc%0d cyc %0d got %b exp %b", k, n, tcv[k], exp_tc(k)); end
`ifdef BCD_CNT_MATCH_EN
                n_cmp++;
                if (mat[k] !== (reset && mv[k] == bcd2int(cmp_val))) begin
                    n_fail++; $display("FAIL rnd_match%0d cyc %0d got %b exp %b", k, n, mat[k], (reset && mv[k] == bcd2int(cmp_val)));
                end
`endif
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (cnt[k] !== int2bcd(mv[k])) begin n_fail++; $display("FAIL rnd_count%0d cyc %0d got %h exp %h", k, n, cnt[k], int2bcd(mv[k])); end
                n_cmp++;
                if (dwv[k] !== mdw[k]) begin n_fail++; $display("FAIL rnd_dw%0d cyc %0d got %b exp %b", k, n, dwv[k], mdw[k]); end
                n_cmp++;
                if (errv[k] !== merr[k]) begin n_fail++; $display("FAIL rnd_err%0d cyc %0d got %b exp %b", k, n, errv[k], merr[k]); end
            end
        end
    endtask

    initial begin
        mv[0] = 0; mv[1] = 0;
        mdw[0] = '0; mdw[1] = '0;
        merr[0] = 1'b0; merr[1] = 1'b0;
        test_reset();
        test_up_wrap();
        test_down_bound();
        test_load();
        test_mid_op();
`ifdef BCD_CNT_MATCH_EN
        test_match();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
